// File: rtl/multicycle_control_pkg.sv
// Shared RV32I control definitions: ALU operation codes, major opcodes and
// the sequencer state type. Imported by the decoder, the top and the bench.
package multicycle_control_pkg;

    // ALU operation codes driven on alu_control_en.
    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b1000,
        ALU_AND  = 4'b0111,
        ALU_OR   = 4'b0110,
        ALU_XOR  = 4'b0100,
        ALU_SLL  = 4'b0001,
        ALU_SRL  = 4'b0101,
        ALU_SRA  = 4'b1101,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011
    } alu_op_t;

    // Major opcodes (instruction bits [6:0]).
    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // Sequencer states; TRAP is only reachable when the illegal trap is built in.
    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } ctrl_state_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Instruction and data memory handshakes between the sequencer (master) and
// the memory system (slave).
//
// Handshake rules: the master raises imem_req / dmem_req and holds it, with
// dmem_we stable, until the slave answers with a one-cycle imem_rvalid /
// dmem_ready; the transfer completes on the rising edge where request and
// answer are both high. imem_rdata is only meaningful while imem_rvalid is 1,
// and answers arriving while no request is pending are ignored.
interface multicycle_control_if;
    logic        imem_req;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ready;

    modport master (
        output imem_req, dmem_req, dmem_we,
        input  imem_rvalid, imem_rdata, dmem_ready
    );

    modport slave (
        input  imem_req, dmem_req, dmem_we,
        output imem_rvalid, imem_rdata, dmem_ready
    );
endinterface

// File: rtl/multicycle_control_alu_decoder.sv
// Combinational ALU decoder: {opcode, funct3, funct7[5]} -> {alu_op, legal}.
// Unknown opcodes and R-type funct combinations outside the ten base
// operations are flagged illegal and decode to ADD.
module multicycle_control_alu_decoder
    import multicycle_control_pkg::*;
(
    input  logic [6:0] opcode_i,
    input  logic [2:0] f3_i,
    input  logic       f7_5_i,
    output alu_op_t    alu_op_o,
    output logic       legal_o
);

    // The alu_op_t encoding equals {f7[5], f3} for every base R-type operation.
    always_comb begin
        alu_op_o = ALU_ADD;
        legal_o  = 1'b1;
        case (opcode_i)
            OPC_R: begin
                case ({f7_5_i, f3_i})
                    4'b0000, 4'b1000, 4'b0001, 4'b0010, 4'b0011,
                    4'b0100, 4'b0101, 4'b1101, 4'b0110, 4'b0111:
                        alu_op_o = alu_op_t'({f7_5_i, f3_i});
                    default: legal_o = 1'b0;
                endcase
            end
            // funct7[5] only distinguishes SRAI from SRLI; elsewhere it is immediate bits.
            OPC_I: begin
                if (f3_i == 3'b101) begin
                    alu_op_o = alu_op_t'({f7_5_i, f3_i});
                end else begin
                    alu_op_o = alu_op_t'({1'b0, f3_i});
                end
            end
            OPC_LOAD, OPC_STORE: alu_op_o = ALU_ADD;
            OPC_BRANCH:          alu_op_o = ALU_SUB;
            default:             legal_o  = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I sequencer: FETCH -> DECODE -> EXEC -> (MEM) -> (WB),
// driving PC, register-file, ALU and memory strobes for the shared datapath.
// Build option ILLEGAL_TRAP_EN: illegal instructions lock the sequencer in
// TRAP with a sticky illegal_instr flag; without it they retire as a NOP.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    multicycle_control_if.master mem,
    input  logic                 branch_taken,
    output logic [31:0]          instr_q,
    output logic                 pc_write_en,
    output logic                 pc_src_sel,
    output logic                 alu_src_b_sel,
    output logic [3:0]           alu_control_en,
    output logic                 wb_sel,
    output logic                 register_write_en,
    output logic [CNT_W-1:0]     retired_count,
    output logic                 illegal_instr,
    output ctrl_state_t          dbg_state_o
);

    ctrl_state_t      state_q, state_d;
    logic [31:0]      ir_q;
    logic [CNT_W-1:0] cnt_q;
    logic             ir_load;
    logic             retire;
    logic             imem_req, dmem_req, dmem_we;
    alu_op_t          dec_op;
    logic             dec_legal;
    logic             is_load, is_store;

    multicycle_control_alu_decoder u_alu_decoder (
        .opcode_i (ir_q[6:0]),
        .f3_i     (ir_q[14:12]),
        .f7_5_i   (ir_q[30]),
        .alu_op_o (dec_op),
        .legal_o  (dec_legal)
    );

    assign is_load  = (ir_q[6:0] == OPC_LOAD);
    assign is_store = (ir_q[6:0] == OPC_STORE);

`ifdef ILLEGAL_TRAP_EN
    logic trap_set;
`endif

    // Next state and strobes; everything is forced low while reset is held.
    always_comb begin
        state_d           = state_q;
        ir_load           = 1'b0;
        retire            = 1'b0;
        imem_req          = 1'b0;
        dmem_req          = 1'b0;
        dmem_we           = 1'b0;
        pc_write_en       = 1'b0;
        pc_src_sel        = 1'b0;
        alu_src_b_sel     = 1'b0;
        alu_control_en    = 4'b0000;
        wb_sel            = 1'b0;
        register_write_en = 1'b0;
`ifdef ILLEGAL_TRAP_EN
        trap_set          = 1'b0;
`endif
        if (!reset) begin
            case (state_q)
                ST_FETCH: begin
                    imem_req = 1'b1;
                    if (mem.imem_rvalid) begin
                        ir_load = 1'b1;
                        state_d = ST_DECODE;
                    end
                end
                ST_DECODE: state_d = ST_EXEC;
                ST_EXEC: begin
                    alu_control_en = dec_op;
                    if (!dec_legal) begin
`ifdef ILLEGAL_TRAP_EN
                        trap_set = 1'b1;
                        state_d  = ST_TRAP;
`else
                        pc_write_en = 1'b1;
                        retire      = 1'b1;
                        state_d     = ST_FETCH;
`endif
                    end else begin
                        case (ir_q[6:0])
                            OPC_R: state_d = ST_WB;
                            OPC_I: begin
                                alu_src_b_sel = 1'b1;
                                state_d       = ST_WB;
                            end
                            OPC_LOAD, OPC_STORE: begin
                                alu_src_b_sel = 1'b1;
                                state_d       = ST_MEM;
                            end
                            OPC_BRANCH: begin
                                pc_write_en = 1'b1;
                                pc_src_sel  = branch_taken;
                                retire      = 1'b1;
                                state_d     = ST_FETCH;
                            end
                            default: state_d = ST_FETCH;
                        endcase
                    end
                end
                ST_MEM: begin
                    alu_control_en = dec_op;
                    dmem_req       = 1'b1;
                    dmem_we        = is_store;
                    if (mem.dmem_ready) begin
                        if (is_store) begin
                            pc_write_en = 1'b1;
                            retire      = 1'b1;
                            state_d     = ST_FETCH;
                        end else begin
                            state_d = ST_WB;
                        end
                    end
                end
                ST_WB: begin
                    alu_control_en    = dec_op;
                    register_write_en = (ir_q[11:7] != 5'd0);
                    wb_sel            = is_load;
                    pc_write_en       = 1'b1;
                    retire            = 1'b1;
                    state_d           = ST_FETCH;
                end
                ST_TRAP: state_d = ST_TRAP;
                default: state_d = ST_FETCH;
            endcase
        end
    end

    // State, instruction register and retired-instruction counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_FETCH;
            ir_q    <= 32'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (ir_load) ir_q  <= mem.imem_rdata;
            if (retire)  cnt_q <= cnt_q + CNT_W'(1);
        end
    end

`ifdef ILLEGAL_TRAP_EN
    logic illegal_q;

    // Sticky illegal flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset)         illegal_q <= 1'b0;
        else if (trap_set) illegal_q <= 1'b1;
    end

    assign illegal_instr = illegal_q;
`else
    assign illegal_instr = 1'b0;
`endif

    assign mem.imem_req  = imem_req;
    assign mem.dmem_req  = dmem_req;
    assign mem.dmem_we   = dmem_we;
    assign instr_q       = ir_q;
    assign retired_count = cnt_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed vector table, hand-written reset and
// illegal-instruction sequences, and randomized instructions checked cycle by
// cycle against a phase-level reference model.
module tb_multicycle_control;
    import multicycle_control_pkg::*;

    localparam int CW = 4;  // small counter so wrap-around is exercised
`ifdef ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    localparam int K_R = 0, K_I = 1, K_LD = 2, K_ST = 3, K_BR = 4, K_ILL = 5;
    localparam int P_F = 0, P_D = 1, P_E = 2, P_M = 3, P_W = 4, P_T = 5;

    // ---------------- clock / reset / DUT ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    multicycle_control_if mem_if ();
    logic          branch_taken;
    logic [31:0]   instr_q;
    logic          pc_write_en, pc_src_sel, alu_src_b_sel, wb_sel, register_write_en;
    logic [3:0]    alu_control_en;
    logic [CW-1:0] retired_count;
    logic          illegal_instr;
    ctrl_state_t   dbg_state;

    multicycle_control #(.CNT_W(CW)) dut (
        .clk               (clk),
        .reset             (reset),
        .mem               (mem_if),
        .branch_taken      (branch_taken),
        .instr_q           (instr_q),
        .pc_write_en       (pc_write_en),
        .pc_src_sel        (pc_src_sel),
        .alu_src_b_sel     (alu_src_b_sel),
        .alu_control_en    (alu_control_en),
        .wb_sel            (wb_sel),
        .register_write_en (register_write_en),
        .retired_count     (retired_count),
        .illegal_instr     (illegal_instr),
        .dbg_state_o       (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    int exp_count = 0;
    logic [CW-1:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // {imem_req, dmem_req, dmem_we, pc_we, pc_src, alu[3:0], wb_sel, reg_we}
    function automatic logic [10:0] obs();
        return {mem_if.imem_req, mem_if.dmem_req, mem_if.dmem_we, pc_write_en,
                pc_src_sel, alu_control_en, wb_sel, register_write_en};
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        int         kind;
        logic [3:0] alu;
        logic       srcb;
    } ref_t;

    function automatic ref_t ref_decode(input logic [31:0] ins);
        ref_t r;
        logic [2:0] f3;
        logic       f7;
        f3     = ins[14:12];
        f7     = ins[30];
        r.kind = K_ILL;
        r.alu  = 4'b0000;
        r.srcb = 1'b0;
        case (ins[6:0])
            7'b0110011: begin
                r.kind = K_R;
                if (!f7) begin
                    case (f3)
                        3'd0: r.alu = ALU_ADD;
                        3'd1: r.alu = ALU_SLL;
                        3'd2: r.alu = ALU_SLT;
                        3'd3: r.alu = ALU_SLTU;
                        3'd4: r.alu = ALU_XOR;
                        3'd5: r.alu = ALU_SRL;
                        3'd6: r.alu = ALU_OR;
                        default: r.alu = ALU_AND;
                    endcase
                end else if (f3 == 3'd0) r.alu = ALU_SUB;
                else if (f3 == 3'd5) r.alu = ALU_SRA;
                else r.kind = K_ILL;
            end
            7'b0010011: begin
                r.kind = K_I;
                r.srcb = 1'b1;
                case (f3)
                    3'd0: r.alu = ALU_ADD;
                    3'd1: r.alu = ALU_SLL;
                    3'd2: r.alu = ALU_SLT;
                    3'd3: r.alu = ALU_SLTU;
                    3'd4: r.alu = ALU_XOR;
                    3'd5: r.alu = f7 ? ALU_SRA : ALU_SRL;
                    3'd6: r.alu = ALU_OR;
                    default: r.alu = ALU_AND;
                endcase
            end
            7'b0000011: begin r.kind = K_LD; r.alu = ALU_ADD; r.srcb = 1'b1; end
            7'b0100011: begin r.kind = K_ST; r.alu = ALU_ADD; r.srcb = 1'b1; end
            7'b1100011: begin r.kind = K_BR; r.alu = ALU_SUB; r.srcb = 1'b0; end
            default: ;
        endcase
        return r;
    endfunction

    // ---------------- driver tasks ----------------
    // Entered and left at posedge+1 with the sequencer expected in FETCH.
    task automatic run_instr(input logic [31:0] ins, input logic bt, input int iw,
                             input int dw, output logic [3:0] exec_alu,
                             output logic exec_srcb);
        ref_t       r;
        int         ph[$];
        logic [10:0] e;
        bit         trap_ill;
        r        = ref_decode(ins);
        trap_ill = (r.kind == K_ILL) && TRAP;
        exec_alu  = 4'hx;
        exec_srcb = 1'bx;
        for (int i = 0; i <= iw; i++) ph.push_back(P_F);
        ph.push_back(P_D);
        ph.push_back(P_E);
        if (r.kind == K_LD || r.kind == K_ST)
            for (int i = 0; i <= dw; i++) ph.push_back(P_M);
        if (r.kind == K_LD || r.kind == K_R || r.kind == K_I) ph.push_back(P_W);
        if (trap_ill) for (int i = 0; i < 3; i++) ph.push_back(P_T);

        for (int idx = 0; idx < ph.size(); idx++) begin
            bit last_f, last_m;
            last_f = (ph[idx] == P_F) && (idx == iw);
            last_m = (ph[idx] == P_M) && ((idx + 1 == ph.size()) || (ph[idx+1] != P_M));
            mem_if.imem_rvalid = last_f ? 1'b1 :
                                 (ph[idx] != P_F) ? 1'($urandom_range(0, 1)) : 1'b0;
            mem_if.imem_rdata  = last_f ? ins : $urandom;
            mem_if.dmem_ready  = last_m;
            branch_taken       = bt;
            e = '0;
            case (ph[idx])
                P_F: e[10] = 1'b1;
                P_E: begin
                    e[5:2] = r.alu;
                    if (r.kind == K_BR) begin e[7] = 1'b1; e[6] = bt; end
                    if (r.kind == K_ILL && !TRAP) e[7] = 1'b1;
                end
                P_M: begin
                    e[9]   = 1'b1;
                    e[8]   = (r.kind == K_ST);
                    e[5:2] = r.alu;
                    if (last_m && r.kind == K_ST) e[7] = 1'b1;
                end
                P_W: begin
                    e[0]   = (ins[11:7] != 5'd0);
                    e[1]   = (r.kind == K_LD);
                    e[7]   = 1'b1;
                    e[5:2] = r.alu;
                end
                default: ;
            endcase
            @(negedge clk);
            chk($sformatf("strobes_ph%0d_%h", ph[idx], ins), 32'(obs()), 32'(e));
            chk("count_hold", 32'(retired_count), 32'(exp_count));
            if (ph[idx] == P_D) chk("instr_q", instr_q, ins);
            if (ph[idx] == P_E) begin
                exec_alu  = alu_control_en;
                exec_srcb = alu_src_b_sel;
                chk("exec_src_b", 32'(alu_src_b_sel), 32'(r.srcb));
            end
            @(posedge clk);
            #1;
        end
        mem_if.imem_rvalid = 1'b0;
        mem_if.dmem_ready  = 1'b0;
        if (!trap_ill) begin
            exp_count = (exp_count + 1) % (1 << CW);
            exp_q.push_back(CW'(exp_count));
        end
        @(negedge clk);
        if (exp_q.size() > 0) chk("retired", 32'(retired_count), 32'(exp_q[$]));
        else chk("retired", 32'(retired_count), 32'(exp_count));
        chk("illegal_flag", 32'(illegal_instr), 32'(trap_ill));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset              = 1'b1;
        mem_if.imem_rvalid = 1'b0;
        mem_if.dmem_ready  = 1'b0;
        @(negedge clk);
        chk("reset_strobes", 32'(obs()), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset_strobes2", 32'(obs()), 32'd0);
        chk("reset_instr_q", instr_q, 32'd0);
        chk("reset_count", 32'(retired_count), 32'd0);
        chk("reset_illegal", 32'(illegal_instr), 32'd0);
        @(posedge clk);
        #1;
        reset     = 1'b0;
        exp_count = 0;
        exp_q.delete();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [31:0] ins;
        logic        bt;
        int          iw;
        int          dw;
        logic [3:0]  alu;
        logic        srcb;
    } vec_t;

    vec_t vt[10];

    initial begin
        logic [3:0] ea;
        logic       es;
        logic [31:0] ins;
        reset              = 1'b1;
        branch_taken       = 1'b0;
        mem_if.imem_rvalid = 1'b0;
        mem_if.imem_rdata  = 32'd0;
        mem_if.dmem_ready  = 1'b0;

        vt[0] = '{32'h002081B3, 1'b0, 0, 0, 4'b0000, 1'b0};  // add
        vt[1] = '{32'h402081B3, 1'b0, 0, 0, 4'b1000, 1'b0};  // sub
        vt[2] = '{32'h00500093, 1'b0, 0, 0, 4'b0000, 1'b1};  // addi
        vt[3] = '{32'h40515093, 1'b0, 0, 0, 4'b1101, 1'b1};  // srai
        vt[4] = '{32'h0020F1B3, 1'b0, 0, 0, 4'b0111, 1'b0};  // and
        vt[5] = '{32'h0000A283, 1'b0, 0, 2, 4'b0000, 1'b1};  // lw, ready on 3rd MEM cycle
        vt[6] = '{32'h0050A223, 1'b0, 0, 0, 4'b0000, 1'b1};  // sw
        vt[7] = '{32'h00208463, 1'b1, 0, 0, 4'b1000, 1'b0};  // beq taken
        vt[8] = '{32'h00208463, 1'b0, 0, 0, 4'b1000, 1'b0};  // beq not taken
        vt[9] = '{32'h0000A283, 1'b0, 2, 0, 4'b0000, 1'b1};  // lw, slow fetch

        @(posedge clk);
        #1;
        do_reset();

        for (int i = 0; i < 10; i++) begin
            run_instr(vt[i].ins, vt[i].bt, vt[i].iw, vt[i].dw, ea, es);
            chk($sformatf("vec%0d_alu", i), 32'(ea), 32'(vt[i].alu));
            chk($sformatf("vec%0d_src_b", i), 32'(es), 32'(vt[i].srcb));
        end

        // All-zero word and an undefined R-type funct pair.
        run_instr(32'h00000000, 1'b0, 0, 0, ea, es);
        do_reset();
        run_instr(32'h402091B3, 1'b0, 0, 0, ea, es);
        do_reset();

        // Reset while a load is waiting in MEM.
        run_instr(32'h002081B3, 1'b0, 0, 0, ea, es);
        mem_if.imem_rvalid = 1'b1;
        mem_if.imem_rdata  = 32'h0000A283;
        @(posedge clk); #1;                       // -> DECODE
        mem_if.imem_rvalid = 1'b0;
        @(posedge clk); #1;                       // -> EXEC
        @(posedge clk); #1;                       // -> MEM
        @(negedge clk);
        chk("mem_wait_req", 32'(mem_if.dmem_req), 32'd1);
        chk("mem_wait_we", 32'(mem_if.dmem_we), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("mid_reset_strobes", 32'(obs()), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("post_reset_fetch", 32'(mem_if.imem_req), 32'd1);
        chk("post_reset_dmem_req", 32'(mem_if.dmem_req), 32'd0);
        chk("post_reset_instr_q", instr_q, 32'd0);
        chk("post_reset_count", 32'(retired_count), 32'd0);
        exp_count = 0;
        exp_q.delete();
        @(posedge clk); #1;

        // Randomized instruction stream.
        for (int n = 0; n < 60; n++) begin
            int   k;
            ref_t r;
            k   = $urandom_range(0, 6);
            ins = $urandom;
            case (k)
                0: begin ins[6:0] = 7'b0110011; ins[31:25] = {1'b0, 1'($urandom_range(0, 1)), 5'd0}; end
                1: begin
                    ins[6:0] = 7'b0010011;
                    if (ins[14:12] == 3'b101) ins[31:25] = {1'b0, 1'($urandom_range(0, 1)), 5'd0};
                end
                2: ins[6:0] = 7'b0000011;
                3: ins[6:0] = 7'b0100011;
                4: ins[6:0] = 7'b1100011;
                5: ins[6:0] = 7'b0110011;
                default: ;
            endcase
            r = ref_decode(ins);
            run_instr(ins, 1'($urandom_range(0, 1)), $urandom_range(0, 2),
                      $urandom_range(0, 2), ea, es);
            chk("rand_alu", 32'(ea), 32'(r.alu));
            if (r.kind == K_ILL) do_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
